// File: rtl/pc_sequencer.sv
// pc_sequencer -- instruction-fetch controller driving a 32-bit program counter.
//
// Re-vectors the PC after reset, issues one instruction read per PC value,
// presents the fetched word to the decoder under a valid/ready handshake and
// then either increments the PC or loads a branch target. PC commands are
// issued from the rising edge; the external counter consumes them on the
// falling edge of the same cycle, so the following FETCH sees the new PC.
//
// Optional feature macro: PCSEQ_IRQ_EN adds single-level interrupt entry
// (IRQ_VECTOR, irq/irq_done/irq_ack/epc and the in-interrupt flag).
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst_n      in   synchronous active-low reset
//   pc         in   current program counter value
//   pc_inc     out  increment command to the counter
//   pc_write   out  load command to the counter
//   pc_newv    out  load value
//   mem_req    out  instruction read request
//   mem_addr   out  read address (always equal to pc)
//   mem_ack    in   read complete, mem_data valid this cycle
//   mem_data   in   instruction word
//   ir         out  latched instruction
//   ir_valid   out  ir holds an instruction not yet accepted
//   dec_ready  in   decoder accepts ir
//   br_taken   in   redirect, sampled only in the handshake cycle
//   br_target  in   redirect target
//   halt       in   stop fetching at the next instruction boundary
//   irq        in   interrupt request            (PCSEQ_IRQ_EN only)
//   irq_done   in   end-of-interrupt pulse       (PCSEQ_IRQ_EN only)
//   irq_ack    out  interrupt taken, 1-cycle     (PCSEQ_IRQ_EN only)
//   epc        out  saved return address         (PCSEQ_IRQ_EN only)

module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
`ifdef PCSEQ_IRQ_EN
  , parameter logic [31:0] IRQ_VECTOR = 32'h0000_0010
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        pc_inc,
  output logic        pc_write,
  output logic [31:0] pc_newv,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        dec_ready,
  input  logic        br_taken,
  input  logic [31:0] br_target,
`ifdef PCSEQ_IRQ_EN
  input  logic        irq,
  input  logic        irq_done,
  output logic        irq_ack,
  output logic [31:0] epc,
`endif
  input  logic        halt
);

  localparam logic [2:0] ST_BOOT    = 3'd0;
  localparam logic [2:0] ST_FETCH   = 3'd1;
  localparam logic [2:0] ST_ISSUE   = 3'd2;
  localparam logic [2:0] ST_ADVANCE = 3'd3;
  localparam logic [2:0] ST_HALTED  = 3'd4;

  logic [2:0]  state_r;
  logic [2:0]  state_s;
  logic [31:0] ir_r;
  logic [31:0] newv_r;
  logic        inc_r;
  logic        wr_r;
  logic        handshake_s;

  assign handshake_s = (state_r == ST_ISSUE) && dec_ready;

`ifdef PCSEQ_IRQ_EN
  logic [31:0] epc_r;
  logic        in_irq_r;
  logic        ack_r;
  logic        irq_take_s;

  // Interrupts are one level deep: a request is only honoured outside a handler.
  assign irq_take_s = handshake_s && irq && !in_irq_r;
`endif

  // Next-state selection; halt only acts at instruction boundaries.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_BOOT: begin
        if (halt) state_s = ST_HALTED;
        else      state_s = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ack) state_s = ST_ISSUE;
        else         state_s = ST_FETCH;
      end
      ST_ISSUE: begin
        if (dec_ready) state_s = ST_ADVANCE;
        else           state_s = ST_ISSUE;
      end
      ST_ADVANCE: begin
        if (halt) state_s = ST_HALTED;
        else      state_s = ST_FETCH;
      end
      ST_HALTED: begin
        if (halt) state_s = ST_HALTED;
        else      state_s = ST_FETCH;
      end
      default: state_s = ST_BOOT;
    endcase
  end

  // State, instruction latch and the PC decision captured at the handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_BOOT;
      ir_r    <= 32'h0000_0000;
      newv_r  <= 32'h0000_0000;
      inc_r   <= 1'b0;
      wr_r    <= 1'b0;
    end else begin
      state_r <= state_s;
      // A late ack outside FETCH never touches ir.
      if ((state_r == ST_FETCH) && mem_ack) begin
        ir_r <= mem_data;
      end
      if (handshake_s) begin
`ifdef PCSEQ_IRQ_EN
        if (irq_take_s) begin
          inc_r  <= 1'b0;
          wr_r   <= 1'b1;
          newv_r <= IRQ_VECTOR;
        end else
`endif
        if (br_taken) begin
          inc_r  <= 1'b0;
          wr_r   <= 1'b1;
          newv_r <= br_target;
        end else begin
          inc_r  <= 1'b1;
          wr_r   <= 1'b0;
        end
      end
    end
  end

`ifdef PCSEQ_IRQ_EN
  // Interrupt bookkeeping: entry wins over a simultaneous end-of-interrupt.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      epc_r    <= 32'h0000_0000;
      in_irq_r <= 1'b0;
      ack_r    <= 1'b0;
    end else begin
      if (handshake_s) begin
        ack_r <= irq_take_s;
      end
      if (irq_take_s) begin
        // Return to the branch target if one was taken, else the next word (wraps).
        epc_r    <= br_taken ? br_target : (pc + 32'd1);
        in_irq_r <= 1'b1;
      end else if (irq_done) begin
        in_irq_r <= 1'b0;
      end
    end
  end

  assign irq_ack = (state_r == ST_ADVANCE) && ack_r;
  assign epc     = epc_r;
`endif

  // Outputs are decoded from registered state only; commands are gated by state
  // so stale decision bits never leak outside ADVANCE.
  assign pc_write = (state_r == ST_BOOT) || ((state_r == ST_ADVANCE) && wr_r);
  assign pc_inc   = (state_r == ST_ADVANCE) && inc_r;
  assign pc_newv  = (state_r == ST_BOOT) ? RESET_VECTOR : newv_r;
  assign mem_req  = (state_r == ST_FETCH);
  assign mem_addr = pc;
  assign ir_valid = (state_r == ST_ISSUE);
  assign ir       = ir_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- directed bench for pc_sequencer with RESET_VECTOR=32'h100.
// Models the external program counter (falling-edge update) and a memory that
// returns {16'hA5A5, addr[15:0]} while acked. Interrupt steps are built only
// when PCSEQ_IRQ_EN is defined.

module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] pc = 32'h0000_0000;
  logic        pc_inc;
  logic        pc_write;
  logic [31:0] pc_newv;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic [31:0] ir;
  logic        ir_valid;
  logic        dec_ready;
  logic        br_taken;
  logic [31:0] br_target;
  logic        halt;
`ifdef PCSEQ_IRQ_EN
  logic        irq;
  logic        irq_done;
  logic        irq_ack;
  logic [31:0] epc;
`endif

  int total = 0;
  int bad   = 0;

  pc_sequencer #(.RESET_VECTOR(32'h0000_0100)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .pc_inc(pc_inc), .pc_write(pc_write),
    .pc_newv(pc_newv), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .ir(ir), .ir_valid(ir_valid), .dec_ready(dec_ready),
    .br_taken(br_taken), .br_target(br_target),
`ifdef PCSEQ_IRQ_EN
    .irq(irq), .irq_done(irq_done), .irq_ack(irq_ack), .epc(epc),
`endif
    .halt(halt)
  );

  always #5 clk = ~clk;

  // External counter: consumes commands on the falling edge.
  always @(negedge clk) begin
    if (pc_write)    pc <= pc_newv;
    else if (pc_inc) pc <= pc + 32'd1;
  end

  assign mem_data = mem_ack ? {16'hA5A5, mem_addr[15:0]} : 32'hBAD0_BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ack = 1'b1; dec_ready = 1'b1; br_taken = 1'b0;
    br_target = 32'h0000_0000; halt = 1'b0;
`ifdef PCSEQ_IRQ_EN
    irq = 1'b0; irq_done = 1'b0;
`endif
    // Reset state: BOOT outputs
    tick();
    chk("rst_write", pc_write, 1'b1);
    chk("rst_newv", pc_newv, 32'h0000_0100);
    chk("rst_inc", pc_inc, 1'b0);
    chk("rst_req", mem_req, 1'b0);
    chk("rst_valid", ir_valid, 1'b0);
    chk("rst_ir", ir, 32'h0000_0000);
`ifdef PCSEQ_IRQ_EN
    chk("rst_ack", irq_ack, 1'b0);
    chk("rst_epc", epc, 32'h0000_0000);
`endif
    tick();
    rst_n = 1'b1;

    // Zero-wait memory, always-ready decoder: 3 cycles per instruction
    tick();
    chk("f0_req", mem_req, 1'b1);
    chk("f0_addr", mem_addr, 32'h0000_0100);
    chk("f0_write", pc_write, 1'b0);
    tick();
    chk("i0_valid", ir_valid, 1'b1);
    chk("i0_ir", ir, 32'hA5A5_0100);
    chk("i0_req", mem_req, 1'b0);
    tick();
    chk("a0_inc", pc_inc, 1'b1);
    chk("a0_write", pc_write, 1'b0);
    tick();
    chk("f1_addr", mem_addr, 32'h0000_0101);
    chk("f1_req", mem_req, 1'b1);
    tick();
    tick();
    tick();
    chk("f2_addr", mem_addr, 32'h0000_0102);

    // Memory wait: four cycles without ack keep request and address held
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_req", mem_req, 1'b1);
      chk("wait_addr", mem_addr, 32'h0000_0102);
      chk("wait_cmd", {pc_inc, pc_write}, 2'b00);
      chk("wait_ir", ir, 32'hA5A5_0101);
    end
    mem_ack = 1'b1;
    tick();
    chk("ackw_ir", ir, 32'hA5A5_0102);
    chk("ackw_valid", ir_valid, 1'b1);

    // Decoder stall then branch handshake
    dec_ready = 1'b0;
    tick();
    chk("stall_valid", ir_valid, 1'b1);
    chk("stall_cmd", {pc_inc, pc_write}, 2'b00);
    dec_ready = 1'b1; br_taken = 1'b1; br_target = 32'h0000_0040;
    tick();
    br_taken = 1'b0; br_target = 32'h0000_0000;
    chk("br_write", pc_write, 1'b1);
    chk("br_newv", pc_newv, 32'h0000_0040);
    chk("br_inc", pc_inc, 1'b0);
    tick();
    chk("br_fetch", mem_addr, 32'h0000_0040);
    chk("br_cmd", {pc_inc, pc_write}, 2'b00);
    tick();
    tick();
    tick();
    chk("f41_addr", mem_addr, 32'h0000_0041);

    // Halt during a fetch wait: fetch and retire complete first
    mem_ack = 1'b0; halt = 1'b1;
    tick();
    chk("hw_req", mem_req, 1'b1);
    mem_ack = 1'b1;
    tick();
    chk("hw_issue", ir_valid, 1'b1);
    chk("hw_ir", ir, 32'hA5A5_0041);
    tick();
    chk("hw_inc", pc_inc, 1'b1);
    tick();
    chk("h_req", mem_req, 1'b0);
    chk("h_cmd", {pc_inc, pc_write}, 2'b00);
    tick();
    chk("h_req2", mem_req, 1'b0);
    chk("h_pc", pc, 32'h0000_0042);
    halt = 1'b0;
    tick();
    chk("resume_req", mem_req, 1'b1);
    chk("resume_addr", mem_addr, 32'h0000_0042);

    // Reset during ISSUE
    tick();
    chk("pre_rst_valid", ir_valid, 1'b1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", ir_valid, 1'b0);
    chk("mid_rst_req", mem_req, 1'b0);
    chk("mid_rst_write", pc_write, 1'b1);
    chk("mid_rst_ir", ir, 32'h0000_0000);
    rst_n = 1'b1;
    tick();
    chk("post_rst_addr", mem_addr, 32'h0000_0100);

`ifdef PCSEQ_IRQ_EN
    // Branch to 32'h20, then take an interrupt there
    tick();
    br_taken = 1'b1; br_target = 32'h0000_0020;
    tick();
    br_taken = 1'b0;
    tick();
    chk("irq_pre_addr", mem_addr, 32'h0000_0020);
    tick();
    irq = 1'b1;
    tick();
    chk("irq_ack1", irq_ack, 1'b1);
    chk("irq_write", pc_write, 1'b1);
    chk("irq_newv", pc_newv, 32'h0000_0010);
    chk("irq_epc", epc, 32'h0000_0021);
    chk("irq_inc", pc_inc, 1'b0);
    tick();
    chk("irq_vec_addr", mem_addr, 32'h0000_0010);
    chk("irq_ack_pulse", irq_ack, 1'b0);
    tick();
    tick();
    chk("irq2_ack", irq_ack, 1'b0);
    chk("irq2_inc", pc_inc, 1'b1);
    chk("irq2_epc", epc, 32'h0000_0021);
    tick();
    chk("irq2_addr", mem_addr, 32'h0000_0011);
    irq_done = 1'b1;
    tick();
    irq_done = 1'b0;
    // Interrupt together with a branch: branch target becomes the return address
    br_taken = 1'b1; br_target = 32'h0000_0077;
    tick();
    br_taken = 1'b0;
    chk("irq3_ack", irq_ack, 1'b1);
    chk("irq3_newv", pc_newv, 32'h0000_0010);
    chk("irq3_epc", epc, 32'h0000_0077);
    irq = 1'b0;
    tick();
    chk("irq3_addr", mem_addr, 32'h0000_0010);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
